// File: rtl/fc_readout_capture.sv
// Deserialises FC result rows read back over SRAMDOUT into a small row buffer.
// Tracks the signed argmax across a frame and reports it once the last row lands.
module fc_readout_capture #(
    parameter int WIDTH    = 32,
    parameter int NUM_ROWS = 8,
    parameter int LEAD     = 1,
    localparam int RW      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int CW      = $clog2(WIDTH + LEAD) + 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CLR,
    input  logic             TRIGGER,
    input  logic             SDOUT,
    input  logic [RW-1:0]    RD_ADDR,
    output logic [WIDTH-1:0] RD_DATA,
    output logic [RW-1:0]    CLASS_IDX,
    output logic [WIDTH-1:0] MAX_SCORE,
    output logic             RESULT_VALID,
    output logic             BUSY,
    output logic             ERR,
    output logic [2:0]       STATE_DBG
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SKIP   = 3'd1,
        S_SHIFT  = 3'd2,
        S_STORE  = 3'd3,
        S_WAITLO = 3'd4
    } state_t;

    // bitcnt counts samples taken since the rising edge, the rise cycle itself being sample 0.
    localparam int SKIP_LAST = (LEAD > 1) ? LEAD - 1 : 0;
    localparam int SHIFT_LAST = LEAD + WIDTH - 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic [RW-1:0]    row_q, row_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             trig_q, trig_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [RW-1:0]    idx_q, idx_d;
    logic             pend_q, pend_d;
    logic [RW-1:0]    class_q, class_d;
    logic [WIDTH-1:0] score_q, score_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic [WIDTH-1:0] row_buf_q [NUM_ROWS];
    logic [WIDTH-1:0] row_buf_d [NUM_ROWS];
    logic             rise, fall;

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        row_d     = row_q;
        sr_d      = sr_q;
        err_d     = err_q;
        max_d     = max_q;
        idx_d     = idx_q;
        pend_d    = 1'b0;
        class_d   = class_q;
        score_d   = score_q;
        valid_d   = 1'b0;
        row_buf_d = row_buf_q;
        trig_d    = TRIGGER;
        rise      = TRIGGER & ~trig_q;
        fall      = ~TRIGGER & trig_q;
        // Reading the pre-write array makes a same-address read during STORE return the old word.
        rd_d      = row_buf_q[RD_ADDR];

        if (pend_q) begin
            class_d = idx_q;
            score_d = max_q;
            valid_d = 1'b1;
        end

        if (CLR) begin
            state_d  = S_IDLE;
            row_d    = '0;
            err_d    = 1'b0;
            bitcnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rise) begin
                        bitcnt_d = CW'(1);
                        if (LEAD == 0) begin
                            sr_d    = {sr_q[WIDTH-2:0], SDOUT};
                            state_d = S_SHIFT;
                        end else if (LEAD == 1) begin
                            state_d = S_SHIFT;
                        end else begin
                            state_d = S_SKIP;
                        end
                    end
                end
                S_SKIP: begin
                    if (fall) begin
                        err_d    = 1'b1;
                        bitcnt_d = '0;
                        state_d  = S_IDLE;
                    end else begin
                        bitcnt_d = bitcnt_q + CW'(1);
                        if (bitcnt_q == CW'(SKIP_LAST)) state_d = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (fall) begin
                        err_d    = 1'b1;
                        bitcnt_d = '0;
                        state_d  = S_IDLE;
                    end else begin
                        sr_d     = {sr_q[WIDTH-2:0], SDOUT};
                        bitcnt_d = bitcnt_q + CW'(1);
                        if (bitcnt_q == CW'(SHIFT_LAST)) state_d = S_STORE;
                    end
                end
                S_STORE: begin
                    row_buf_d[row_q] = sr_q;
                    // Strict greater-than keeps the lower index on ties.
                    if ((row_q == '0) || ($signed(sr_q) > $signed(max_q))) begin
                        max_d = sr_q;
                        idx_d = row_q;
                    end
                    if (row_q == LAST_ROW) begin
                        pend_d = 1'b1;
                        row_d  = '0;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                    bitcnt_d = '0;
                    state_d  = S_WAITLO;
                end
                S_WAITLO: begin
                    if (!TRIGGER) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            bitcnt_q <= '0;
            row_q    <= '0;
            sr_q     <= '0;
            trig_q   <= 1'b0;
            err_q    <= 1'b0;
            max_q    <= '0;
            idx_q    <= '0;
            pend_q   <= 1'b0;
            class_q  <= '0;
            score_q  <= '0;
            valid_q  <= 1'b0;
            rd_q     <= '0;
            for (int i = 0; i < NUM_ROWS; i++) row_buf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            row_q     <= row_d;
            sr_q      <= sr_d;
            trig_q    <= trig_d;
            err_q     <= err_d;
            max_q     <= max_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            class_q   <= class_d;
            score_q   <= score_d;
            valid_q   <= valid_d;
            rd_q      <= rd_d;
            row_buf_q <= row_buf_d;
        end
    end

    assign RD_DATA      = rd_q;
    assign CLASS_IDX    = class_q;
    assign MAX_SCORE    = score_q;
    assign RESULT_VALID = valid_q;
    assign BUSY         = (state_q != S_IDLE);
    assign ERR          = err_q;
    assign STATE_DBG    = state_q;

endmodule

// File: tb/tb_fc_readout_capture.sv
// Bench for fc_readout_capture: LEAD=1 instance for framing/argmax/error/reset/clear,
// plus a LEAD=0 instance for the 32-cycle window and bit-order checks.
module tb_fc_readout_capture;

    typedef struct packed {
        logic [7:0][31:0] w;
        logic [2:0]       idx;
        logic [31:0]      mx;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        trig_a = 1'b0, sd_a = 1'b0, trig_b = 1'b0, sd_b = 1'b0;
    logic [2:0]  addr_a = '0, addr_b = '0;
    logic [31:0] rd_a, max_a, rd_b, max_b;
    logic [2:0]  cls_a, cls_b, st_a, st_b;
    logic        val_a, busy_a, err_a, val_b, busy_b, err_b;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          vcnt_a = 0, vcnt_b = 0, vcyc_a = 0, last_edge = 0;
    logic [34:0] exp_q[$];
    logic [34:0] sb_e;
    frame_t      tbl[6];

    fc_readout_capture #(.WIDTH(32), .NUM_ROWS(8), .LEAD(1)) dut_a (
        .CLK(clk), .RST_N(rst_n), .CLR(clr), .TRIGGER(trig_a), .SDOUT(sd_a),
        .RD_ADDR(addr_a), .RD_DATA(rd_a), .CLASS_IDX(cls_a), .MAX_SCORE(max_a),
        .RESULT_VALID(val_a), .BUSY(busy_a), .ERR(err_a), .STATE_DBG(st_a)
    );

    fc_readout_capture #(.WIDTH(32), .NUM_ROWS(8), .LEAD(0)) dut_b (
        .CLK(clk), .RST_N(rst_n), .CLR(1'b0), .TRIGGER(trig_b), .SDOUT(sd_b),
        .RD_ADDR(addr_b), .RD_DATA(rd_b), .CLASS_IDX(cls_b), .MAX_SCORE(max_b),
        .RESULT_VALID(val_b), .BUSY(busy_b), .ERR(err_b), .STATE_DBG(st_b)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: every RESULT_VALID pulse consumes one expected {idx, score}.
    always @(negedge clk) begin
        if (val_a === 1'b1) begin
            vcnt_a++;
            vcyc_a = cyc;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result: got idx %0d score 0x%08h, none expected", cls_a, max_a);
            end else begin
                sb_e = exp_q.pop_front();
                check("result_idx", 32'(cls_a), 32'(sb_e[34:32]));
                check("result_score", max_a, sb_e[31:0]);
            end
        end
        if (val_b === 1'b1) vcnt_b++;
    end

    task automatic set_frame(input int i, input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] a2, input logic [31:0] a3, input logic [31:0] a4,
                             input logic [31:0] a5, input logic [31:0] a6, input logic [31:0] a7,
                             input logic [2:0] ix, input logic [31:0] m);
        tbl[i].w[0] = a0; tbl[i].w[1] = a1; tbl[i].w[2] = a2; tbl[i].w[3] = a3;
        tbl[i].w[4] = a4; tbl[i].w[5] = a5; tbl[i].w[6] = a6; tbl[i].w[7] = a7;
        tbl[i].idx = ix;
        tbl[i].mx = m;
    endtask

    // Drives one row window of hi cycles (bits after one lead cycle, MSB first), then 4 low cycles.
    task automatic send_a(input logic [31:0] w, input int hi, input bit probe, input logic [31:0] old_w);
        for (int k = 0; k < hi + 4; k++) begin
            @(posedge clk); #1;
            trig_a = (k < hi);
            sd_a = (k >= 1 && k <= 32 && k < hi) ? w[32-k] : 1'b0;
            if (k == 32) last_edge = cyc + 1;
            if (probe && (k == 34 || k == 35)) begin
                @(negedge clk);
                check((k == 34) ? "rd_during_store_old" : "rd_after_store_new", rd_a,
                      (k == 34) ? old_w : w);
            end
        end
    endtask

    task automatic send_b(input logic [31:0] w);
        for (int k = 0; k < 36; k++) begin
            @(posedge clk); #1;
            trig_b = (k < 32);
            sd_b = (k < 32) ? w[31-k] : 1'b0;
        end
    endtask

    task automatic read_a(input logic [2:0] a, input logic [31:0] exp, input string name);
        @(posedge clk); #1 addr_a = a;
        @(posedge clk);
        @(negedge clk);
        check(name, rd_a, exp);
    endtask

    task automatic read_b(input logic [2:0] a, input logic [31:0] exp, input string name);
        @(posedge clk); #1 addr_b = a;
        @(posedge clk);
        @(negedge clk);
        check(name, rd_b, exp);
    endtask

    task automatic wait_valid(input int target);
        for (int i = 0; i < 40 && vcnt_a < target; i++) @(negedge clk);
        check("valid_pulse_count", 32'(vcnt_a), 32'(target));
    endtask

    task automatic send_frame(input int f);
        for (int r = 0; r < 8; r++) send_a(tbl[f].w[r], 33, 1'b0, 32'h0);
    endtask

    initial begin
        set_frame(0, 32'd5, 32'hFFFF_FFFD, 32'd100, 32'd7, 32'd100, 32'hFFFF_FFFF, 32'd0, 32'd2,
                  3'd2, 32'd100);
        set_frame(1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                  32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 3'd0, 32'h8000_0000);
        set_frame(2, 32'hFFFF_FFFF, 32'h8000_0000, 32'd3, 32'd0, 32'h7FFF_FFFE, 32'h7FFF_FFFF,
                  32'h7FFF_FFFF, 32'd1, 3'd5, 32'h7FFF_FFFF);
        set_frame(3, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'h1234_5678,
                  3'd7, 32'h1234_5678);
        set_frame(4, 32'd9, 32'd4, 32'hFFFF_FFEC, 32'd0, 32'd50, 32'd49, 32'd50, 32'd3,
                  3'd4, 32'd50);
        set_frame(5, 32'd100, 32'd100, 32'd100, 32'd100, 32'd100, 32'd100, 32'd100, 32'd100,
                  3'd0, 32'd100);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_data", rd_a, 32'h0);
        check("reset_class_idx", 32'(cls_a), 32'h0);
        check("reset_max_score", max_a, 32'h0);
        check("reset_valid", 32'(val_a), 32'h0);
        check("reset_busy", 32'(busy_a), 32'h0);
        check("reset_err", 32'(err_a), 32'h0);
        check("reset_state", 32'(st_a), 32'h0);
        rst_n = 1'b1;
        read_a(3'd5, 32'h0, "reset_buffer");

        // Table-driven frames: argmax, ties, signed extremes, latency, buffer readback
        for (int f = 0; f < 4; f++) begin
            exp_q.push_back({tbl[f].idx, tbl[f].mx});
            if (f == 1) begin
                @(posedge clk); #1 addr_a = 3'd0;
                send_a(tbl[f].w[0], 33, 1'b1, tbl[0].w[0]);
                for (int r = 1; r < 8; r++) send_a(tbl[f].w[r], 33, 1'b0, 32'h0);
            end else begin
                send_frame(f);
            end
            wait_valid(f + 1);
            check("last_bit_to_valid_latency", 32'(vcyc_a - last_edge), 32'd2);
            check("err_clean_frame", 32'(err_a), 32'h0);
            for (int r = 0; r < 8; r++) read_a(3'(r), tbl[f].w[r], "buffer_readback");
        end

        // Row 3 window cut short: error is sticky and the row slot is reused
        exp_q.push_back({tbl[4].idx, tbl[4].mx});
        for (int r = 0; r < 3; r++) send_a(tbl[4].w[r], 33, 1'b0, 32'h0);
        send_a(32'hFFFF_FFFF, 20, 1'b0, 32'h0);
        check("err_after_cut", 32'(err_a), 32'h1);
        check("busy_after_cut", 32'(busy_a), 32'h0);
        for (int r = 3; r < 8; r++) send_a(tbl[4].w[r], 33, 1'b0, 32'h0);
        wait_valid(5);
        check("err_sticky", 32'(err_a), 32'h1);
        read_a(3'd3, tbl[4].w[3], "cut_row_slot");
        read_a(3'd4, tbl[4].w[4], "row_after_cut");

        // Asynchronous reset in the middle of row 4
        for (int r = 0; r < 4; r++) send_a(tbl[0].w[r], 33, 1'b0, 32'h0);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            trig_a = 1'b1;
            sd_a = (k >= 1) ? tbl[0].w[4][32-k] : 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rd_data", rd_a, 32'h0);
        check("async_rst_class_idx", 32'(cls_a), 32'h0);
        check("async_rst_max_score", max_a, 32'h0);
        check("async_rst_busy", 32'(busy_a), 32'h0);
        check("async_rst_err", 32'(err_a), 32'h0);
        trig_a = 1'b0;
        sd_a = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        exp_q.push_back({tbl[2].idx, tbl[2].mx});
        send_frame(2);
        wait_valid(6);
        check("err_after_reset_frame", 32'(err_a), 32'h0);

        // CLR during row 6 drops the frame and holds the previous result
        for (int r = 0; r < 6; r++) send_a(tbl[5].w[r], 33, 1'b0, 32'h0);
        for (int k = 0; k < 37; k++) begin
            @(posedge clk); #1;
            trig_a = (k < 33);
            sd_a = (k >= 1 && k <= 32) ? tbl[5].w[6][32-k] : 1'b0;
            clr = (k == 10);
            if (k == 10) begin
                @(negedge clk);
                check("busy_before_clr", 32'(busy_a), 32'h1);
            end
            if (k == 11) begin
                @(negedge clk);
                check("busy_after_clr", 32'(busy_a), 32'h0);
                check("err_after_clr", 32'(err_a), 32'h0);
                check("class_held_after_clr", 32'(cls_a), 32'(tbl[2].idx));
                check("score_held_after_clr", max_a, tbl[2].mx);
            end
        end
        check("no_result_from_dropped_frame", 32'(vcnt_a), 32'd6);
        exp_q.push_back({tbl[0].idx, tbl[0].mx});
        send_frame(0);
        wait_valid(7);
        check("err_after_clr_frame", 32'(err_a), 32'h0);

        // LEAD=0 instance: 32-cycle windows, MSB-first order
        send_b(32'd1);
        for (int r = 2; r < 8; r++) send_b(32'(r));
        send_b(32'hDEAD_BEEF);
        for (int i = 0; i < 40 && vcnt_b < 1; i++) @(negedge clk);
        check("lead0_valid_count", 32'(vcnt_b), 32'd1);
        check("lead0_class_idx", 32'(cls_b), 32'd6);
        check("lead0_max_score", max_b, 32'd7);
        check("lead0_err", 32'(err_b), 32'h0);
        read_b(3'd7, 32'hDEAD_BEEF, "lead0_row7_word");
        read_b(3'd0, 32'h0000_0001, "lead0_row0_msb_first");

        repeat (4) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
